score_display_scan: RTL and testbench

Scoreboard back end for the breakout top level: takes the multiplexed `current_score` and `high_score` values the top level selects for the active level and drives the 8-digit seven-segment display. Both scores are continuously converted from binary to BCD by a sequential shift-add-3 engine, then time-multiplexed onto shared cathodes. It replaces the purely combinational scoreboard path and gives a registered, glitch-free display with leading-zero blanking and saturation.

---
 rtl/score_display_scan.sv | 187 ++++++++++++++++++
 tb/tb_score_display_scan.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/score_display_scan.sv
// Purpose : binary->BCD scoreboard for two 14-bit scores, scanned onto an 8-digit 7-seg display.
// Latency : display registers follow the inputs 16..31 cycles later; seg/AN are registered, 1 cycle after dig_idx.
// Backpressure: none, free-running. Inputs are sampled once per 16-cycle conversion and ignored in between.
//
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   current_score binary score of the active level, shown on digits 0..3 (AN[3:0])
//   high_score    binary high score of the active level, shown on digits 4..7 (AN[7:4])
//   seg           active-low cathodes, seg[0]=a .. seg[6]=g
//   AN            active-low one-hot digit anodes
//   conv_done     one-cycle pulse in the cycle after the display registers update
module score_display_scan #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] current_score,
    input  logic [13:0] high_score,
    output logic [6:0]  seg,
    output logic [7:0]  AN,
    output logic        conv_done
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_UPDATE
    } state_t;

    // Anything above four decimal digits is shown as 9999.
    function automatic logic [13:0] saturate(input logic [13:0] v);
        return (v > 14'd9999) ? 14'd9999 : v;
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Active-low gfedcba; out-of-range nibbles blank rather than show garbage.
    function automatic logic [6:0] seg_encode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Converter: IDLE (capture) -> 14 x SHIFT -> UPDATE, 16 cycles total
    // ------------------------------------------------------------------
    state_t      state;
    logic [3:0]  shift_cnt;
    logic [13:0] cur_bin;
    logic [13:0] hi_bin;
    logic [15:0] cur_acc;
    logic [15:0] hi_acc;
    logic [15:0] cur_bcd;
    logic [15:0] hi_bcd;

    logic [15:0] cur_adj;
    logic [15:0] hi_adj;
    logic [29:0] cur_shift;
    logic [29:0] hi_shift;

    // {bcd, bin} is treated as one register pair shifted left as a whole.
    always_comb begin
        cur_adj   = bcd_adjust(cur_acc);
        hi_adj    = bcd_adjust(hi_acc);
        cur_shift = {cur_adj, cur_bin} << 1;
        hi_shift  = {hi_adj, hi_bin} << 1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_cnt <= 4'd0;
            cur_bin   <= 14'd0;
            hi_bin    <= 14'd0;
            cur_acc   <= 16'd0;
            hi_acc    <= 16'd0;
            cur_bcd   <= 16'd0;
            hi_bcd    <= 16'd0;
            conv_done <= 1'b0;
        end else begin
            conv_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cur_bin   <= saturate(current_score);
                    hi_bin    <= saturate(high_score);
                    cur_acc   <= 16'd0;
                    hi_acc    <= 16'd0;
                    shift_cnt <= 4'd0;
                    state     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    cur_acc   <= cur_shift[29:14];
                    cur_bin   <= cur_shift[13:0];
                    hi_acc    <= hi_shift[29:14];
                    hi_bin    <= hi_shift[13:0];
                    shift_cnt <= shift_cnt + 4'd1;
                    if (shift_cnt == 4'd13) begin
                        state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    cur_bcd   <= cur_acc;
                    hi_bcd    <= hi_acc;
                    conv_done <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Digit selection and leading-zero blanking
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       dig_idx;
    logic [15:0]      grp;
    logic [3:0]       nib;
    logic             lead_zero;
    logic [6:0]       digit_seg;

    always_comb begin
        grp = dig_idx[2] ? hi_bcd : cur_bcd;
        nib = grp[{dig_idx[1:0], 2'b00} +: 4];
        // Blank when this digit and every higher digit in its group is zero;
        // the ones digit always shows, so a zero score reads "0".
        case (dig_idx[1:0])
            2'd1:    lead_zero = (grp[15:4] == 12'd0);
            2'd2:    lead_zero = (grp[15:8] == 8'd0);
            2'd3:    lead_zero = (grp[15:12] == 4'd0);
            default: lead_zero = 1'b0;
        endcase
        digit_seg = lead_zero ? 7'h7F : seg_encode(nib);
    end

    // ------------------------------------------------------------------
    // Scan: each digit held REFRESH_DIV cycles. AN and seg are registered
    // from the same dig_idx so cathodes and anode switch together.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            dig_idx <= 3'd0;
            seg     <= 7'h7F;
            AN      <= 8'hFF;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                dig_idx <= dig_idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + DIV_ONE;
            end
            AN  <= ~(8'd1 << dig_idx);
            seg <= digit_seg;
        end
    end

endmodule

// File: tb/tb_score_display_scan.sv
module tb_score_display_scan;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] current_score;
    logic [13:0] high_score;
    logic [6:0]  seg;
    logic [7:0]  AN;
    logic        conv_done;

    always #5 clk = ~clk;

    score_display_scan #(.REFRESH_DIV(R)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .current_score (current_score),
        .high_score    (high_score),
        .seg           (seg),
        .AN            (AN),
        .conv_done     (conv_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: k = clock edges since reset release; conversions capture
    // at edge 16j+1 and publish at edge 16j+16.
    int k        = 0;
    int cap_cur  = 0;
    int cap_hi   = 0;
    int disp_cur = 0;
    int disp_hi  = 0;

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic int pow10(input int p);
        case (p)
            0:       return 1;
            1:       return 10;
            2:       return 100;
            default: return 1000;
        endcase
    endfunction

    // Expected cathodes for decimal position p of value v.
    function automatic int exp_seg(input int v, input int p);
        int n;
        if (p > 0 && v < pow10(p)) return 'h7F;
        n = (v / pow10(p)) % 10;
        case (n)
            0: return 'h40;
            1: return 'h79;
            2: return 'h24;
            3: return 'h30;
            4: return 'h19;
            5: return 'h12;
            6: return 'h02;
            7: return 'h78;
            8: return 'h00;
            default: return 'h10;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at k=%0d: got %0h, expected %0h", name, k, act, expv);
        end
    endtask

    // Advance one clock and compare every output against the model.
    task automatic step();
        bit r;
        int d;
        int v;
        r = rst_n;
        @(posedge clk);
        @(negedge clk);
        if (!r) begin
            k        = 0;
            disp_cur = 0;
            disp_hi  = 0;
            chk("rst_seg", int'(seg), 'h7F);
            chk("rst_an", int'(AN), 'hFF);
            chk("rst_conv", int'(conv_done), 0);
        end else begin
            k++;
            d = ((k - 1) / R) % 8;
            v = (d < 4) ? disp_cur : disp_hi;
            chk("seg", int'(seg), exp_seg(v, d % 4));
            chk("an", int'(AN), 'hFF ^ (1 << d));
            chk("conv_done", int'(conv_done), (k % 16 == 0) ? 1 : 0);
            if (k % 16 == 1) begin
                cap_cur = sat(int'(current_score));
                cap_hi  = sat(int'(high_score));
            end
            if (k % 16 == 0) begin
                disp_cur = cap_cur;
                disp_hi  = cap_hi;
            end
        end
    endtask

    // Settle on new inputs, align to a frame start, then compare a whole
    // frame against hand-written cathode values (digit 0 in the low bits).
    task automatic show_frame(input int c, input int h, input logic [55:0] lit, input string name);
        int d;
        current_score = 14'(c);
        high_score    = 14'(h);
        repeat (40) step();
        while (k % (8 * R) != 0) step();
        for (int i = 0; i < 8 * R; i++) begin
            step();
            d = ((k - 1) / R) % 8;
            chk(name, int'(seg), int'(lit[d*7 +: 7]));
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        current_score = 14'd0;
        high_score    = 14'd0;

        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("first_an", int'(AN), 'hFE);
        chk("first_seg", int'(seg), 'h40);
        repeat (15) step();
        chk("first_conv", int'(conv_done), 1);

        show_frame(1234, 5678,
                   {7'h12, 7'h02, 7'h78, 7'h00, 7'h79, 7'h24, 7'h30, 7'h19}, "frame_1234_5678");
        show_frame(7, 0,
                   {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h78}, "frame_7_0");
        show_frame(16383, 10000,
                   {7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10}, "frame_sat");

        // Change during the second SHIFT cycle: the next update still shows 12.
        current_score = 14'd12;
        high_score    = 14'd0;
        repeat (40) step();
        while (k % 16 != 2) step();
        current_score = 14'd345;
        repeat (40) step();

        // Reset in the middle of a conversion while 99 is displayed.
        current_score = 14'd99;
        repeat (40) step();
        while (k % 16 != 5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("midrst_an", int'(AN), 'hFE);
        chk("midrst_seg", int'(seg), 'h40);
        repeat (14) step();
        chk("midrst_noconv", int'(conv_done), 0);
        step();
        chk("midrst_conv", int'(conv_done), 1);

        // Randomized inputs with occasional single-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 2))
                    0:       current_score = 14'($urandom_range(0, 16383));
                    1:       current_score = 14'($urandom_range(0, 20));
                    default: current_score = 14'($urandom_range(9990, 10010));
                endcase
                case ($urandom_range(0, 2))
                    0:       high_score = 14'($urandom_range(0, 16383));
                    1:       high_score = 14'($urandom_range(0, 120));
                    default: high_score = 14'($urandom_range(995, 1005));
                endcase
            end
            rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
